// File: rtl/wav_pkg.sv
// Shared WAV streaming definitions.
// Holds the sender state encoding and the canonical header length. Both are
// shared with parse_wav, so the encodings must stay stable.
package wav_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StHeader  = 3'd1,
    StSamples = 3'd2,
    StDone    = 3'd3
  } wav_state_e;

  // Canonical PCM WAV header: RIFF + fmt + data chunk headers.
  localparam int unsigned HeaderLen = 44;

endpackage

// File: rtl/uart_transmit.sv
// 8N1 UART byte serializer.
// Ports:
//   clk_in     - clock
//   rst_in     - synchronous active-high reset; aborts any byte in flight
//   data_in    - byte to send, captured when trigger_in is accepted
//   trigger_in - load request; accepted whenever busy_out is low
//   busy_out   - transmitter cannot take a byte this cycle
//   tx_out     - serial line, idles high
// The start bit appears on tx_out the cycle after a load. busy_out drops during
// the final cycle of the stop bit so a caller can chain the next byte with no
// idle gap on the line.
module uart_transmit #(
  parameter int unsigned CLOCK_SPEED = 100_000_000,
  parameter int unsigned BAUD_RATE   = 57600
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic       trigger_in,
  output logic       busy_out,
  output logic       tx_out
);

  localparam int unsigned BitPeriod = CLOCK_SPEED / BAUD_RATE;
  localparam int unsigned BaudW     = $clog2(BitPeriod + 1);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(BitPeriod - 1);

  logic [9:0]       frame_q, frame_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [3:0]       bit_q, bit_d;
  logic             active_q, active_d;
  logic             last_cycle;
  logic             load;

  assign last_cycle = active_q && (baud_q == BaudLast) && (bit_q == 4'd9);
  assign busy_out   = active_q && !last_cycle;
  assign load       = trigger_in && !busy_out;
  assign tx_out     = active_q ? frame_q[0] : 1'b1;

  always_comb begin
    frame_d  = frame_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    active_d = active_q;
    if (load) begin
      // Frame shifts out LSB first: start(0), data[0..7], stop(1).
      frame_d  = {1'b1, data_in, 1'b0};
      baud_d   = '0;
      bit_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (baud_q == BaudLast) begin
        baud_d  = '0;
        frame_d = {1'b1, frame_q[9:1]};
        bit_d   = bit_q + 4'd1;
        if (bit_q == 4'd9) begin
          active_d = 1'b0;
        end
      end else begin
        baud_d = baud_q + BaudW'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      frame_q  <= '1;
      baud_q   <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
    end else begin
      frame_q  <= frame_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/wav_uart_sender.sv
// Streams one 8-bit mono PCM WAV file over a UART.
// Ports:
//   clk_in           - sole clock
//   rst_in           - synchronous active-high reset, overrides all inputs
//   start_in         - begin one file (honoured only when idle)
//   sample_in        - signed 8-bit sample
//   sample_valid_in  - sample_in is valid
//   sample_ready_out - a sample is accepted this cycle if valid
//   uart_txd         - serial output, idles high
//   busy_out         - high whenever not idle
//   done_out         - one-cycle pulse when the file is complete
//   state_out        - current state, for debug
// Sends the 44-byte header back-to-back, then one line byte per accepted
// sample, then pulses done_out and returns to idle.
module wav_uart_sender
  import wav_pkg::*;
#(
  parameter int unsigned CLOCK_SPEED = 100_000_000,
  parameter int unsigned BAUD_RATE   = 57600,
  parameter int unsigned SAMPLE_RATE = 12_000,
  parameter int unsigned NUM_SAMPLES = 12_000 * 60
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  input  logic [7:0] sample_in,
  input  logic       sample_valid_in,
  output logic       sample_ready_out,
  output logic       uart_txd,
  output logic       busy_out,
  output logic       done_out,
  output logic [2:0] state_out
);

  localparam int unsigned SampleW = $clog2(NUM_SAMPLES + 1);
  localparam logic [SampleW-1:0] SampleLast    = SampleW'(NUM_SAMPLES);
  localparam logic [5:0]         HeaderLastIdx = 6'(HeaderLen - 1);
  localparam logic [31:0]        RiffSize      = 32'(36 + NUM_SAMPLES);
  localparam logic [31:0]        DataSize      = 32'(NUM_SAMPLES);
  localparam logic [31:0]        SampleRate    = 32'(SAMPLE_RATE);

  function automatic logic [7:0] le_byte(input logic [31:0] v, input logic [1:0] k);
    return v[{k, 3'b000} +: 8];
  endfunction

  // ASCII tags are written as they read, so the first character is the MSB.
  function automatic logic [7:0] be_byte(input logic [31:0] v, input logic [1:0] k);
    return v[{~k, 3'b000} +: 8];
  endfunction

  // Header ROM: the header is eleven 4-byte words.
  function automatic logic [7:0] header_byte(input logic [5:0] idx);
    logic [7:0] b;
    case (idx[5:2])
      4'd0:    b = be_byte(32'h5249_4646, idx[1:0]);  // "RIFF"
      4'd1:    b = le_byte(RiffSize, idx[1:0]);
      4'd2:    b = be_byte(32'h5741_5645, idx[1:0]);  // "WAVE"
      4'd3:    b = be_byte(32'h666d_7420, idx[1:0]);  // "fmt "
      4'd4:    b = le_byte(32'd16, idx[1:0]);
      4'd5:    b = le_byte(32'h0001_0001, idx[1:0]);  // PCM format, mono
      4'd6:    b = le_byte(SampleRate, idx[1:0]);
      4'd7:    b = le_byte(SampleRate, idx[1:0]);     // byte rate at 1 byte/sample
      4'd8:    b = le_byte(32'h0008_0001, idx[1:0]);  // block align 1, 8 bits
      4'd9:    b = be_byte(32'h6461_7461, idx[1:0]);  // "data"
      4'd10:   b = le_byte(DataSize, idx[1:0]);
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  wav_state_e         state_q, state_d;
  logic [5:0]         hdr_idx_q, hdr_idx_d;
  logic [SampleW-1:0] smp_cnt_q, smp_cnt_d;
  logic               prev_busy_q;
  logic               tx_busy;
  logic               tx_trigger;
  logic [7:0]         tx_data;

  uart_transmit #(
    .CLOCK_SPEED(CLOCK_SPEED),
    .BAUD_RATE  (BAUD_RATE)
  ) u_uart_transmit (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .data_in   (tx_data),
    .trigger_in(tx_trigger),
    .busy_out  (tx_busy),
    .tx_out    (uart_txd)
  );

  // tx_busy already drops in the last stop-bit cycle; prev_busy_q masks that
  // cycle so a sample is only taken once the line is truly idle.
  assign sample_ready_out = (state_q == StSamples) && !tx_busy && !prev_busy_q &&
                            (smp_cnt_q != SampleLast);
  assign busy_out  = (state_q != StIdle);
  assign state_out = state_q;

  always_comb begin
    state_d    = state_q;
    hdr_idx_d  = hdr_idx_q;
    smp_cnt_d  = smp_cnt_q;
    tx_trigger = 1'b0;
    tx_data    = {~sample_in[7], sample_in[6:0]};  // signed -> offset-binary
    done_out   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          state_d    = StHeader;
          hdr_idx_d  = '0;
          smp_cnt_d  = '0;
          tx_trigger = 1'b1;
          tx_data    = header_byte(6'd0);
        end
      end
      StHeader: begin
        // tx_busy is only low here in the final stop-bit cycle of a byte.
        if (!tx_busy) begin
          if (hdr_idx_q == HeaderLastIdx) begin
            state_d = StSamples;
          end else begin
            hdr_idx_d  = hdr_idx_q + 6'd1;
            tx_trigger = 1'b1;
            tx_data    = header_byte(hdr_idx_q + 6'd1);
          end
        end
      end
      StSamples: begin
        if (sample_valid_in && sample_ready_out) begin
          smp_cnt_d  = smp_cnt_q + SampleW'(1);
          tx_trigger = 1'b1;
        end else if ((smp_cnt_q == SampleLast) && !tx_busy) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done_out = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      hdr_idx_q   <= '0;
      smp_cnt_q   <= '0;
      prev_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_idx_q   <= hdr_idx_d;
      smp_cnt_q   <= smp_cnt_d;
      prev_busy_q <= tx_busy;
    end
  end

endmodule

// File: tb/tb_wav_uart_sender.sv
// Directed bench for wav_uart_sender: header bytes and timing, sample
// conversion, backpressure, done pulse, and mid-byte reset.
module tb_wav_uart_sender;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] sample;
  logic       sample_valid;
  logic       sample_ready;
  logic       txd;
  logic       busy;
  logic       done;
  logic [2:0] state;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int frame_err = 0;
  int busy_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wav_uart_sender #(
    .CLOCK_SPEED(100),
    .BAUD_RATE  (10),
    .SAMPLE_RATE(12000),
    .NUM_SAMPLES(4)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .start_in        (start),
    .sample_in       (sample),
    .sample_valid_in (sample_valid),
    .sample_ready_out(sample_ready),
    .uart_txd        (txd),
    .busy_out        (busy),
    .done_out        (done),
    .state_out       (state)
  );

  logic [7:0] exp_hdr   [16] = '{8'h52, 8'h49, 8'h46, 8'h46, 8'h28, 8'h00, 8'h00, 8'h00,
                                 8'hE0, 8'h2E, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
  int         exp_idx   [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 24, 25, 26, 27, 40, 41, 42, 43};
  logic [7:0] smp_vals  [4]  = '{8'h80, 8'h7F, 8'h00, 8'hFF};
  logic [7:0] smp_bytes [4]  = '{8'h00, 8'hFF, 8'h80, 8'h7F};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Finds a start bit (current cycle first), then samples each bit mid-period.
  // Returns on the cycle at the middle of the stop bit.
  task automatic uart_rx(output logic [7:0] b, output int s);
    int n = 0;
    b = '0;
    s = -1;
    while (txd !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("rx_start_found", 32'(txd === 1'b0), 32'(1));
    if (txd === 1'b0) begin
      s = cyc;
      repeat (5) @(negedge clk);
      if (txd !== 1'b0) frame_err++;
      if (busy !== 1'b1) busy_err++;
      for (int i = 0; i < 8; i++) begin
        repeat (10) @(negedge clk);
        b[i] = txd;
        if (busy !== 1'b1) busy_err++;
      end
      repeat (10) @(negedge clk);
      if (txd !== 1'b1) frame_err++;
    end
  endtask

  task automatic wait_ready(output int acc);
    int n = 0;
    while (sample_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_found", 32'(sample_ready === 1'b1), 32'(1));
    acc = cyc;
  endtask

  initial begin
    logic [7:0] hdr [44];
    int         hs  [44];
    logic [7:0] b;
    int         s, t0, acc, prev_s, gap_err, bp_err;

    rst = 1'b1;
    start = 1'b0;
    sample = 8'h00;
    sample_valid = 1'b0;
    gap_err = 0;
    prev_s = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_txd", 32'(txd), 32'(1));
    check_eq("rst_ready", 32'(sample_ready), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_done", 32'(done), 32'(0));
    check_eq("rst_state", 32'(state), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // Header: valid is already held so ready must stay low until samples.
    sample = smp_vals[0];
    sample_valid = 1'b1;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    check_eq("hdr_txd_fall", 32'(txd), 32'(0));
    check_eq("hdr_state", 32'(state), 32'(1));
    check_eq("hdr_busy", 32'(busy), 32'(1));
    check_eq("hdr_ready_low", 32'(sample_ready), 32'(0));
    for (int k = 0; k < 44; k++) begin
      uart_rx(hdr[k], hs[k]);
      if (k > 0 && hs[k] != hs[k-1] + 100) gap_err++;
      if (k == 20) begin
        // start outside idle must be ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    check_eq("hdr_first_start", 32'(hs[0]), 32'(t0 + 1));
    check_eq("hdr_back_to_back", 32'(gap_err), 32'(0));
    for (int j = 0; j < 16; j++) begin
      check_eq($sformatf("hdr_byte%0d", exp_idx[j]), 32'(hdr[exp_idx[j]]), 32'(exp_hdr[j]));
    end
    repeat (4) @(negedge clk);
    check_eq("hdr_last_cycle_state", 32'(state), 32'(1));
    check_eq("hdr_last_cycle_ready", 32'(sample_ready), 32'(0));
    @(negedge clk);
    check_eq("hdr_end_cycle", 32'(cyc), 32'(t0 + 1 + 4400));
    check_eq("smp_state", 32'(state), 32'(2));
    check_eq("smp_txd_idle", 32'(txd), 32'(1));
    check_eq("hdr_busy_throughout", 32'(busy_err), 32'(0));

    // Samples, with a 500-cycle valid gap before the third.
    for (int i = 0; i < 4; i++) begin
      wait_ready(acc);
      if (i == 0) check_eq("smp0_ready_cycle", 32'(acc), 32'(t0 + 4401));
      else check_eq($sformatf("smp%0d_ready_cycle", i), 32'(acc), 32'(prev_s + 100));
      if (i == 2) begin
        bp_err = 0;
        for (int k = 0; k < 500; k++) begin
          if (txd !== 1'b1 || sample_ready !== 1'b1) bp_err++;
          @(negedge clk);
        end
        check_eq("bp_idle", 32'(bp_err), 32'(0));
        sample_valid = 1'b1;
        acc = cyc;
      end
      @(posedge clk);
      #1;
      if (i < 3) sample = smp_vals[i+1];
      @(negedge clk);
      uart_rx(b, s);
      check_eq($sformatf("smp%0d_byte", i), 32'(b), 32'(smp_bytes[i]));
      check_eq($sformatf("smp%0d_start_cycle", i), 32'(s), 32'(acc + 1));
      prev_s = s;
      if (i == 1) sample_valid = 1'b0;
    end
    repeat (4) @(negedge clk);
    check_eq("done_early", 32'(done), 32'(0));
    @(negedge clk);
    check_eq("done_pulse", 32'(done), 32'(1));
    check_eq("done_state", 32'(state), 32'(3));
    check_eq("done_no_extra_ready", 32'(sample_ready), 32'(0));
    @(negedge clk);
    check_eq("done_single", 32'(done), 32'(0));
    check_eq("end_state", 32'(state), 32'(0));
    check_eq("end_busy", 32'(busy), 32'(0));
    check_eq("end_txd", 32'(txd), 32'(1));

    // Reset in the middle of data bit 3 of header byte 10 ('V' = 0x56).
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10; k++) uart_rx(b, s);
    check_eq("rst_hdr_byte9", 32'(b), 32'(8'h41));
    repeat (50) @(negedge clk);
    check_eq("rst_pre_bit", 32'(txd), 32'(0));
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_abort_txd", 32'(txd), 32'(1));
    check_eq("rst_abort_state", 32'(state), 32'(0));
    check_eq("rst_abort_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_idle_txd", 32'(txd), 32'(1));
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    uart_rx(b, s);
    check_eq("restart_byte0", 32'(b), 32'(8'h52));
    check_eq("restart_cycle", 32'(s), 32'(t0 + 1));
    check_eq("framing", 32'(frame_err), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
